// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_reader
// Brief    : Drains a synchronous FIFO into a valid/ready stream through a
//            3-entry skid buffer; read enable never depends on m_ready.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_reader #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_dataout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [7:0]        xfer_count
);

    localparam logic [1:0] c_LAST_IDX = 2'd2;
    localparam logic [2:0] c_CAPACITY = 3'd3;

    logic [DATA_W-1:0] r_buf [0:2];
    logic [1:0]        r_head;
    logic [1:0]        r_tail;
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [7:0]        r_xfer_count;

    logic [2:0]        w_fill;
    logic              w_ren;
    logic              w_pop;

    function automatic logic [1:0] f_inc(input logic [1:0] p);
        return (p == c_LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when a slot is guaranteed for its data next cycle,
    // so m_ready never has to reach the FIFO read enable.
    assign w_fill = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_ren  = !reset && en && !fifo_empty && (w_fill < c_CAPACITY);
    assign w_pop  = (r_occ != 2'd0) && m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head       <= 2'd0;
            r_tail       <= 2'd0;
            r_occ        <= 2'd0;
            r_inflight   <= 1'b0;
            r_xfer_count <= 8'd0;
        end else begin
            r_inflight <= w_ren;
            if (r_inflight) begin
                r_tail <= f_inc(r_tail);
            end
            if (w_pop) begin
                r_head       <= f_inc(r_head);
                r_xfer_count <= r_xfer_count + 8'd1;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage carries no reset: contents are meaningless while r_occ is zero.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_buf[r_tail] <= fifo_dataout;
        end
    end

    assign fifo_ren   = w_ren;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf[r_head];
    assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_reader
// Brief    : Scoreboard bench for fifo_reader with a behavioural upstream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

    localparam int DATA_W = 4;

    logic              clk;
    logic              reset;
    logic              en;
    logic              fifo_empty;
    logic              fifo_ren;
    logic [DATA_W-1:0] fifo_dataout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [7:0]        xfer_count;

    fifo_reader #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_ren     (fifo_ren),
        .fifo_dataout (fifo_dataout),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .xfer_count   (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] fifo_mem [0:511];
    int                wr_idx = 0;
    int                rd_idx = 0;
    logic              rd_pend = 1'b0;
    assign fifo_empty = (rd_idx == wr_idx);

    logic [DATA_W-1:0] sb [$];
    int                ren_log [$];
    int                hs_log [$];
    int                cyc = 0;
    int                vcnt = 0;
    int                n_cmp = 0;
    int                n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Upstream FIFO: data appears on fifo_dataout the cycle after the read.
    always @(posedge clk) begin
        if (rd_pend && rd_idx < wr_idx) begin
            fifo_dataout <= fifo_mem[rd_idx];
            rd_idx       <= rd_idx + 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        rd_pend = 1'b0;
        if (reset) begin
            sb.delete();
        end else begin
            if (m_valid) vcnt++;
            if (fifo_ren && fifo_empty) check_eq("ren_on_empty", 1, 0);
            if (fifo_ren) begin
                rd_pend = 1'b1;
                ren_log.push_back(cyc);
                sb.push_back(fifo_mem[rd_idx]);
            end
            if (m_valid && m_ready) begin
                hs_log.push_back(cyc);
                if (sb.size() == 0) check_eq("sb_underflow", 1, 0);
                else check_eq("data_order", 32'(m_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ren_log.delete();
        hs_log.delete();
        vcnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fifo_mem[wr_idx + i] = DATA_W'($urandom);
        wr_idx = wr_idx + n;
    endtask

    int base;

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;
        load(2);
        tick(2);
        // Reset holds everything quiet even with work pending.
        check_eq("rst_ren", 32'(fifo_ren), 0);
        check_eq("rst_valid", 32'(m_valid), 0);
        check_eq("rst_xfer", 32'(xfer_count), 0);
        en    = 1'b0;
        reset = 1'b0;
        clear_logs();
        #1;
        check_eq("post_rst_ren_en0", 32'(fifo_ren), 0);
        en = 1'b1;
        #1;
        check_eq("post_rst_ren_en1", 32'(fifo_ren), 1);
        tick(6);
        check_eq("warmup_xfer", 32'(xfer_count), 2);

        // Preloaded 1,2,3,4: back-to-back reads, 2-cycle latency, one per cycle.
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 4; i++) fifo_mem[wr_idx + i] = DATA_W'(i + 1);
        wr_idx = wr_idx + 4;
        en = 1'b1;
        m_ready = 1'b1;
        tick(10);
        check_eq("t30_nren", ren_log.size(), 4);
        check_eq("t30_nhs", hs_log.size(), 4);
        if (ren_log.size() == 4 && hs_log.size() == 4) begin
            check_eq("t30_ren_consec", ren_log[3] - ren_log[0], 3);
            check_eq("t30_latency", hs_log[0] - ren_log[0], 2);
            check_eq("t30_hs_consec", hs_log[3] - hs_log[0], 3);
        end
        check_eq("t30_xfer", 32'(xfer_count), 4);

        // Backpressure: exactly three reads, head word held steady.
        do_reset();
        en = 1'b0;
        m_ready = 1'b0;
        base = wr_idx;
        load(8);
        en = 1'b1;
        tick(10);
        check_eq("t31_nren", ren_log.size(), 3);
        check_eq("t31_valid", 32'(m_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t31_hold", 32'(m_data), 32'(fifo_mem[base]));
        end
        tick(1);
        m_ready = 1'b1;
        tick(15);
        check_eq("t31_nhs", hs_log.size(), 8);
        check_eq("t31_xfer", 32'(xfer_count), 8);
        check_eq("t31_sb_empty", sb.size(), 0);

        // Empty FIFO: no reads, nothing presented.
        do_reset();
        en = 1'b1;
        tick(10);
        check_eq("t32_nren", ren_log.size(), 0);
        check_eq("t32_valid_cycles", vcnt, 0);

        // en high for one read: that word still arrives, then nothing.
        do_reset();
        en = 1'b0;
        m_ready = 1'b1;
        load(4);
        en = 1'b1;
        tick(1);
        en = 1'b0;
        tick(8);
        check_eq("t33_nren_en0", ren_log.size(), 1);
        check_eq("t33_nhs_en0", hs_log.size(), 1);
        en = 1'b1;
        tick(8);
        check_eq("t33_nren", ren_log.size(), 4);
        check_eq("t33_xfer", 32'(xfer_count), 4);

        // Reset with two buffered words and one in flight.
        do_reset();
        en = 1'b1;
        m_ready = 1'b1;
        load(10);
        tick(5);
        m_ready = 1'b0;
        tick(1);
        check_eq("t34_pre_nren", ren_log.size(), 6);
        check_eq("t34_pre_nhs", hs_log.size(), 3);
        reset = 1'b1;
        #1;
        check_eq("t34_valid", 32'(m_valid), 0);
        check_eq("t34_xfer", 32'(xfer_count), 0);
        check_eq("t34_ren", 32'(fifo_ren), 0);
        tick(2);
        reset = 1'b0;
        clear_logs();
        m_ready = 1'b1;
        tick(10);
        check_eq("t34_post_nhs", hs_log.size(), 4);
        check_eq("t34_post_xfer", 32'(xfer_count), 4);

        // 300 transfers: full throughput and counter wrap.
        do_reset();
        en = 1'b0;
        load(300);
        en = 1'b1;
        m_ready = 1'b1;
        tick(310);
        check_eq("t35_nhs", hs_log.size(), 300);
        if (hs_log.size() == 300) check_eq("t35_rate", hs_log[299] - hs_log[0], 299);
        check_eq("t35_xfer", 32'(xfer_count), 44);
        check_eq("t35_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
